// File: rtl/inst_queue_pkg.sv
//------------------------------------------------------------------------------
// inst_queue_pkg
// Shared constants and types for the decoding instruction queue.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package inst_queue_pkg;

    // Internal opcodes; numbering is shared with the dispatcher.
    localparam logic [6:0] OP_NONE  = 7'd0;
    localparam logic [6:0] OP_LUI   = 7'd1;
    localparam logic [6:0] OP_AUIPC = 7'd2;
    localparam logic [6:0] OP_JAL   = 7'd3;
    localparam logic [6:0] OP_JALR  = 7'd4;
    localparam logic [6:0] OP_BEQ   = 7'd5;
    localparam logic [6:0] OP_BNE   = 7'd6;
    localparam logic [6:0] OP_BLT   = 7'd7;
    localparam logic [6:0] OP_BGE   = 7'd8;
    localparam logic [6:0] OP_BLTU  = 7'd9;
    localparam logic [6:0] OP_BGEU  = 7'd10;
    localparam logic [6:0] OP_LB    = 7'd11;
    localparam logic [6:0] OP_LH    = 7'd12;
    localparam logic [6:0] OP_LW    = 7'd13;
    localparam logic [6:0] OP_LBU   = 7'd14;
    localparam logic [6:0] OP_LHU   = 7'd15;
    localparam logic [6:0] OP_SB    = 7'd16;
    localparam logic [6:0] OP_SH    = 7'd17;
    localparam logic [6:0] OP_SW    = 7'd18;
    localparam logic [6:0] OP_ADDI  = 7'd19;
    localparam logic [6:0] OP_SLTI  = 7'd20;
    localparam logic [6:0] OP_SLTIU = 7'd21;
    localparam logic [6:0] OP_XORI  = 7'd22;
    localparam logic [6:0] OP_ORI   = 7'd23;
    localparam logic [6:0] OP_ANDI  = 7'd24;
    localparam logic [6:0] OP_SLLI  = 7'd25;
    localparam logic [6:0] OP_SRLI  = 7'd26;
    localparam logic [6:0] OP_SRAI  = 7'd27;
    localparam logic [6:0] OP_ADD   = 7'd28;
    localparam logic [6:0] OP_SUB   = 7'd29;
    localparam logic [6:0] OP_SLL   = 7'd30;
    localparam logic [6:0] OP_SLT   = 7'd31;
    localparam logic [6:0] OP_SLTU  = 7'd32;
    localparam logic [6:0] OP_XOR   = 7'd33;
    localparam logic [6:0] OP_SRL   = 7'd34;
    localparam logic [6:0] OP_SRA   = 7'd35;
    localparam logic [6:0] OP_OR    = 7'd36;
    localparam logic [6:0] OP_AND   = 7'd37;

    // RV32I major opcodes
    localparam logic [6:0] MAJ_LUI    = 7'b0110111;
    localparam logic [6:0] MAJ_AUIPC  = 7'b0010111;
    localparam logic [6:0] MAJ_JAL    = 7'b1101111;
    localparam logic [6:0] MAJ_JALR   = 7'b1100111;
    localparam logic [6:0] MAJ_BRANCH = 7'b1100011;
    localparam logic [6:0] MAJ_LOAD   = 7'b0000011;
    localparam logic [6:0] MAJ_STORE  = 7'b0100011;
    localparam logic [6:0] MAJ_OPIMM  = 7'b0010011;
    localparam logic [6:0] MAJ_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } dec_t;

    typedef struct packed {
        logic [31:0] pc;
        dec_t        dec;
        logic        predict;
    } iq_entry_t;

    function automatic logic is_branch(input logic [6:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_queue_if.sv
//------------------------------------------------------------------------------
// inst_queue_if
// Fetch-side and dispatch-side signals of the instruction queue.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface inst_queue_if;
    logic        rdy_in;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_pc;
    logic        fetch_predict;
    logic        fetch_ready;
    logic        RoB_flush_signal;
    logic        new_instruction_able;
    logic        new_instruction_en;
    logic [31:0] new_pc;
    logic [6:0]  new_opcode;
    logic [4:0]  new_rs1;
    logic [4:0]  new_rs2;
    logic [4:0]  new_rd;
    logic [31:0] new_imm;
    logic        new_predict_result;

    modport master (
        output rdy_in, fetch_valid, fetch_inst, fetch_pc, fetch_predict,
               RoB_flush_signal, new_instruction_able,
        input  fetch_ready, new_instruction_en, new_pc, new_opcode,
               new_rs1, new_rs2, new_rd, new_imm, new_predict_result
    );

    modport slave (
        input  rdy_in, fetch_valid, fetch_inst, fetch_pc, fetch_predict,
               RoB_flush_signal, new_instruction_able,
        output fetch_ready, new_instruction_en, new_pc, new_opcode,
               new_rs1, new_rs2, new_rd, new_imm, new_predict_result
    );
endinterface

`default_nettype wire

// File: rtl/inst_queue_decoder.sv
//------------------------------------------------------------------------------
// inst_decoder
// Combinational RV32I decoder: raw word -> internal opcode, registers, immediate.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_decoder
    import inst_queue_pkg::*;
(
    input  wire logic [31:0] i_inst,
    output dec_t             o_dec
);

    logic [2:0] w_f3;
    logic       w_b30;
    logic [6:0] w_op;
    fmt_e       w_fmt;

    assign w_f3  = i_inst[14:12];
    assign w_b30 = i_inst[30];

    always_comb begin
        w_op  = OP_NONE;
        w_fmt = FMT_NONE;
        case (i_inst[6:0])
            MAJ_LUI:   begin w_op = OP_LUI;   w_fmt = FMT_U; end
            MAJ_AUIPC: begin w_op = OP_AUIPC; w_fmt = FMT_U; end
            MAJ_JAL:   begin w_op = OP_JAL;   w_fmt = FMT_J; end
            MAJ_JALR:  if (w_f3 == 3'd0) begin w_op = OP_JALR; w_fmt = FMT_I; end
            MAJ_BRANCH: begin
                w_fmt = FMT_B;
                case (w_f3)
                    3'd0:    w_op = OP_BEQ;
                    3'd1:    w_op = OP_BNE;
                    3'd4:    w_op = OP_BLT;
                    3'd5:    w_op = OP_BGE;
                    3'd6:    w_op = OP_BLTU;
                    3'd7:    w_op = OP_BGEU;
                    default: w_op = OP_NONE;
                endcase
            end
            MAJ_LOAD: begin
                w_fmt = FMT_I;
                case (w_f3)
                    3'd0:    w_op = OP_LB;
                    3'd1:    w_op = OP_LH;
                    3'd2:    w_op = OP_LW;
                    3'd4:    w_op = OP_LBU;
                    3'd5:    w_op = OP_LHU;
                    default: w_op = OP_NONE;
                endcase
            end
            MAJ_STORE: begin
                w_fmt = FMT_S;
                case (w_f3)
                    3'd0:    w_op = OP_SB;
                    3'd1:    w_op = OP_SH;
                    3'd2:    w_op = OP_SW;
                    default: w_op = OP_NONE;
                endcase
            end
            MAJ_OPIMM: begin
                w_fmt = FMT_I;
                case (w_f3)
                    3'd0: w_op = OP_ADDI;
                    3'd2: w_op = OP_SLTI;
                    3'd3: w_op = OP_SLTIU;
                    3'd4: w_op = OP_XORI;
                    3'd6: w_op = OP_ORI;
                    3'd7: w_op = OP_ANDI;
                    3'd1: begin w_op = OP_SLLI; w_fmt = FMT_SH; end
                    default: begin w_op = w_b30 ? OP_SRAI : OP_SRLI; w_fmt = FMT_SH; end
                endcase
            end
            MAJ_OP: begin
                w_fmt = FMT_R;
                case (w_f3)
                    3'd0:    w_op = w_b30 ? OP_SUB : OP_ADD;
                    3'd1:    w_op = OP_SLL;
                    3'd2:    w_op = OP_SLT;
                    3'd3:    w_op = OP_SLTU;
                    3'd4:    w_op = OP_XOR;
                    3'd5:    w_op = w_b30 ? OP_SRA : OP_SRL;
                    3'd6:    w_op = OP_OR;
                    default: w_op = OP_AND;
                endcase
            end
            default: ;
        endcase
        if (w_op == OP_NONE) w_fmt = FMT_NONE;
    end

    // Fields absent from a format stay zero so downstream never sees stale bits.
    always_comb begin
        o_dec    = '0;
        o_dec.op = w_op;
        case (w_fmt)
            FMT_R: begin
                o_dec.rs1 = i_inst[19:15];
                o_dec.rs2 = i_inst[24:20];
                o_dec.rd  = i_inst[11:7];
            end
            FMT_I: begin
                o_dec.rs1 = i_inst[19:15];
                o_dec.rd  = i_inst[11:7];
                o_dec.imm = {{20{i_inst[31]}}, i_inst[31:20]};
            end
            FMT_SH: begin
                o_dec.rs1 = i_inst[19:15];
                o_dec.rd  = i_inst[11:7];
                o_dec.imm = {27'b0, i_inst[24:20]};
            end
            FMT_S: begin
                o_dec.rs1 = i_inst[19:15];
                o_dec.rs2 = i_inst[24:20];
                o_dec.imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            end
            FMT_B: begin
                o_dec.rs1 = i_inst[19:15];
                o_dec.rs2 = i_inst[24:20];
                o_dec.imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                             i_inst[30:25], i_inst[11:8], 1'b0};
            end
            FMT_U: begin
                o_dec.rd  = i_inst[11:7];
                o_dec.imm = {i_inst[31:12], 12'b0};
            end
            FMT_J: begin
                o_dec.rd  = i_inst[11:7];
                o_dec.imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                             i_inst[20], i_inst[30:21], 1'b0};
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/inst_queue.sv
//------------------------------------------------------------------------------
// inst_queue
// Decoding instruction FIFO between fetch and dispatch; flushed on mispredict.
// Optional IQ_BYPASS_EN: zero-latency pass-through when the queue is empty.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int IQ_WIDTH = 2
) (
    input wire logic    clk_in,
    input wire logic    rst_in,
    inst_queue_if.slave iq
);

    localparam int c_DEPTH = 1 << IQ_WIDTH;

    iq_entry_t               r_mem [c_DEPTH];
    logic [IQ_WIDTH-1:0]     r_head;
    logic [IQ_WIDTH-1:0]     r_tail;
    logic [IQ_WIDTH:0]       r_count;

    dec_t      w_dec;
    iq_entry_t w_in;
    iq_entry_t w_head;
    logic      w_full, w_empty, w_ready, w_accept, w_deq, w_bypass, w_push;

    inst_decoder u_dec (
        .i_inst (iq.fetch_inst),
        .o_dec  (w_dec)
    );

    assign w_in.pc      = iq.fetch_pc;
    assign w_in.dec     = w_dec;
    assign w_in.predict = iq.fetch_predict && is_branch(w_dec.op);
    assign w_head       = r_mem[r_head];

    assign w_full   = (r_count == (IQ_WIDTH+1)'(c_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_ready  = iq.rdy_in && !rst_in && !w_full && !iq.RoB_flush_signal;
    assign w_accept = iq.fetch_valid && w_ready;
    assign w_deq    = iq.rdy_in && !rst_in && !w_empty && iq.new_instruction_able
                      && !iq.RoB_flush_signal;

`ifdef IQ_BYPASS_EN
    assign w_bypass = w_accept && w_empty && iq.new_instruction_able && (w_dec.op != OP_NONE);
`else
    assign w_bypass = 1'b0;
`endif

    // Unsupported encodings are consumed from fetch but never stored.
    assign w_push = w_accept && (w_dec.op != OP_NONE) && !w_bypass;

    always_comb begin
        iq.fetch_ready        = w_ready;
        iq.new_instruction_en = w_deq || w_bypass;
        iq.new_pc             = '0;
        iq.new_opcode         = '0;
        iq.new_rs1            = '0;
        iq.new_rs2            = '0;
        iq.new_rd             = '0;
        iq.new_imm            = '0;
        iq.new_predict_result = 1'b0;
        if (w_bypass) begin
            iq.new_pc             = w_in.pc;
            iq.new_opcode         = w_in.dec.op;
            iq.new_rs1            = w_in.dec.rs1;
            iq.new_rs2            = w_in.dec.rs2;
            iq.new_rd             = w_in.dec.rd;
            iq.new_imm            = w_in.dec.imm;
            iq.new_predict_result = w_in.predict;
        end else if (!w_empty && !rst_in) begin
            iq.new_pc             = w_head.pc;
            iq.new_opcode         = w_head.dec.op;
            iq.new_rs1            = w_head.dec.rs1;
            iq.new_rs2            = w_head.dec.rs2;
            iq.new_rd             = w_head.dec.rd;
            iq.new_imm            = w_head.dec.imm;
            iq.new_predict_result = w_head.predict;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || iq.RoB_flush_signal) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_deq)  r_head <= r_head + 1'b1;
            case ({w_push, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_tail] <= w_in;
    end

endmodule

`default_nettype wire
